// File: rtl/img_pkg.sv
// Shared types and helpers for the stream pixel parser: FSM states,
// header length and byte-lane placement within a packed pixel.
package img_pkg;

  typedef enum logic [1:0] {HDR, CHK, PIX, DRAIN} state_t;

  localparam int DEF_DIM_W = 16;
  localparam int HDR_BYTES = 2 * DEF_DIM_W / 8;

  // Header length in bytes for a given height/width field width.
  function automatic int hdr_bytes(input int dim_w);
    return 2 * dim_w / 8;
  endfunction

  // LSB position of byte k in a pixel; byte 0 lands in the MSBs.
  function automatic int lane_lsb(input int num_ch, input int k);
    return 8 * (num_ch - 1 - k);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Collects NUM_CH bytes into one word. word_done/word_out are valid in the
// cycle the final byte is presented, so the caller can register the word.
module byte_packer
  import img_pkg::*;
#(
  parameter int NUM_CH = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [7:0]          byte_in,
  input  logic                byte_en,
  output logic [8*NUM_CH-1:0] word_out,
  output logic                word_done
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_CH - 1);

  logic [IW-1:0]       idx;
  logic [8*NUM_CH-1:0] shadow;

  always_comb begin
    word_out = shadow;
    for (int k = 0; k < NUM_CH; k++) begin
      if (idx == IW'(k)) word_out[lane_lsb(NUM_CH, k) +: 8] = byte_in;
    end
  end

  assign word_done = byte_en && (idx == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      idx    <= '0;
      shadow <= '0;
    end else if (byte_en) begin
      shadow <= word_out;
      idx    <= (idx == LAST) ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/stream_pixel_parser.sv
// Parses a big-endian height/width header followed by packed pixel bytes and
// emits whole pixels downstream, one frame at a time.
module stream_pixel_parser
  import img_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int DIM_W  = DEF_DIM_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [8*NUM_CH-1:0] m_pixel,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DIM_W-1:0]    height,
  output logic [DIM_W-1:0]    width,
  output logic                dim_valid,
  output logic                frame_done,
  output logic                zero_dim_err,
  output logic [1:0]          state_dbg
);

  localparam int HDR_N = hdr_bytes(DIM_W);
  localparam int HW    = $clog2(HDR_N);
  localparam int CW    = 2 * DIM_W;
  localparam logic [HW-1:0] HDR_LAST = HW'(HDR_N - 1);

  state_t state, state_nxt;

  logic [HW-1:0]       hdr_cnt;
  logic [CW-9:0]       hdr_sr;
  logic [CW-1:0]       hdr_word, total, pix_cnt, pix_cnt_inc;
  logic [8*NUM_CH-1:0] word;
  logic byte_xfer, pix_xfer, pix_load, dim_zero, frame_end;

  // Handshake: a transfer happens on any clock edge where valid && ready.
  // s_ready in PIX follows m_ready combinationally; the pixel register frees
  // up in the same cycle it is accepted downstream.
  assign s_ready = (state == HDR) || ((state == PIX) && (!m_valid || m_ready));

  assign byte_xfer    = s_valid && s_ready;
  assign pix_xfer     = m_valid && m_ready;
  assign hdr_word     = {hdr_sr, s_data};
  assign dim_zero     = (height == '0) || (width == '0);
  assign pix_cnt_inc  = pix_cnt + CW'(1);
  assign frame_end    = pix_load && (pix_cnt_inc == total);
  assign zero_dim_err = (state == CHK) && dim_zero;
  assign frame_done   = (state == DRAIN) && pix_xfer;
  assign state_dbg    = state;

  byte_packer #(.NUM_CH(NUM_CH)) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (state == CHK),
    .byte_in   (s_data),
    .byte_en   ((state == PIX) && byte_xfer),
    .word_out  (word),
    .word_done (pix_load)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= HDR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HDR:   if (s_valid && (hdr_cnt == HDR_LAST)) state_nxt = CHK;
      CHK:   state_nxt = dim_zero ? HDR : PIX;
      PIX:   if (frame_end) state_nxt = DRAIN;
      DRAIN: if (pix_xfer) state_nxt = HDR;
      default: state_nxt = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_cnt   <= '0;
      hdr_sr    <= '0;
      height    <= '0;
      width     <= '0;
      total     <= '0;
      pix_cnt   <= '0;
      m_pixel   <= '0;
      m_valid   <= 1'b0;
      dim_valid <= 1'b0;
    end else begin
      if ((state == HDR) && byte_xfer) begin
        hdr_sr <= hdr_word[CW-9:0];
        if (hdr_cnt == HDR_LAST) begin
          hdr_cnt <= '0;
          height  <= hdr_word[CW-1:DIM_W];
          width   <= hdr_word[DIM_W-1:0];
        end else begin
          hdr_cnt <= hdr_cnt + HW'(1);
        end
      end
      if ((state == CHK) && !dim_zero) begin
        total     <= CW'(height) * CW'(width);
        pix_cnt   <= '0;
        dim_valid <= 1'b1;
      end
      // A fresh pixel overrides the clear from a same-cycle downstream accept.
      if (pix_load) begin
        m_pixel <= word;
        m_valid <= 1'b1;
        pix_cnt <= pix_cnt_inc;
      end else if (pix_xfer) begin
        m_valid <= 1'b0;
      end
      if ((state == DRAIN) && pix_xfer) dim_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_pixel_parser.sv
// Bench for stream_pixel_parser: frame-level reference model feeding an
// expected-pixel queue, random upstream gaps and downstream stalls.
module tb_stream_pixel_parser;

  localparam int NCH = 3;
  localparam int DW  = 16;
  localparam int PW  = 8 * NCH;
  localparam int EW  = PW + 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0]    s_data;
  logic          s_valid, s_ready, m_valid, m_ready;
  logic [PW-1:0] m_pixel;
  logic [DW-1:0] height, width;
  logic          dim_valid, frame_done, zero_dim_err;
  logic [1:0]    state_dbg;

  logic [7:0]  b_s_data;
  logic        b_s_valid, b_s_ready, b_m_valid, b_m_ready;
  logic [31:0] b_m_pixel;
  logic [7:0]  b_height, b_width;
  logic        b_dim_valid, b_frame_done, b_zero_dim_err;
  logic [1:0]  b_state_dbg;

  stream_pixel_parser #(.NUM_CH(NCH), .DIM_W(DW)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_pixel(m_pixel), .m_valid(m_valid), .m_ready(m_ready), .height(height), .width(width),
    .dim_valid(dim_valid), .frame_done(frame_done), .zero_dim_err(zero_dim_err),
    .state_dbg(state_dbg)
  );

  stream_pixel_parser #(.NUM_CH(4), .DIM_W(8)) dut_b (
    .clk(clk), .reset(reset), .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .m_pixel(b_m_pixel), .m_valid(b_m_valid), .m_ready(b_m_ready), .height(b_height),
    .width(b_width), .dim_valid(b_dim_valid), .frame_done(b_frame_done),
    .zero_dim_err(b_zero_dim_err), .state_dbg(b_state_dbg)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [EW-1:0] exp_q[$];   // {dim_valid, last_of_frame, pixel}
  logic [8:0]    byte_q[$];  // {completes_pixel, byte}

  int ready_mode, valid_pct, cyc;
  int fd_cnt, exp_fd, zerr_cnt, exp_zerr;
  int last_h, last_w;
  bit hold, prev_stall, pend_lat;
  logic [PW-1:0] prev_pixel;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a frame is its header followed by h*w pixels of NCH bytes.
  task automatic push_frame(input int h, input int w, input logic [7:0] base,
                            input logic [7:0] inc, input bit rnd);
    logic [PW-1:0] px;
    logic [7:0] b;
    byte_q.push_back({1'b0, 8'(h >> 8)});
    byte_q.push_back({1'b0, 8'(h)});
    byte_q.push_back({1'b0, 8'(w >> 8)});
    byte_q.push_back({1'b0, 8'(w)});
    if (h == 0 || w == 0) begin
      exp_zerr++;
      return;
    end
    last_h = h;
    last_w = w;
    exp_fd++;
    for (int p = 0; p < h * w; p++) begin
      px = '0;
      for (int k = 0; k < NCH; k++) begin
        b  = rnd ? 8'($urandom_range(0, 255)) : 8'(base + 8'(p * NCH + k) * inc);
        px = {px[PW-9:0], b};
        byte_q.push_back({(k == NCH - 1), b});
      end
      exp_q.push_back({1'b1, (p == h * w - 1), px});
    end
  endtask

  task automatic step();
    bit bx, pxx;
    @(negedge clk);
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: m_ready = ($urandom_range(0, 99) < 60);
    endcase
    if (byte_q.size() == 0) s_valid = 1'b0;
    else if (hold || $urandom_range(0, 99) < valid_pct) begin
      s_valid = 1'b1;
      s_data  = byte_q[0][7:0];
    end else s_valid = 1'b0;
    #1;
    if (prev_stall) begin
      check("stall_valid", m_valid, 1);
      check("stall_pixel", m_pixel, prev_pixel);
    end
    if (m_valid && !m_ready) check("s_ready_stall", s_ready, 0);
    if (pend_lat) check("latency", m_valid, 1);
    bx  = s_valid && s_ready;
    pxx = m_valid && m_ready;
    if (pxx) begin
      if (exp_q.size() == 0) check("pix_extra", m_valid, 0);
      else check("pixel", {dim_valid, frame_done, m_pixel}, exp_q.pop_front());
    end
    if (frame_done && !pxx) check("fd_spurious", frame_done, 0);
    if (frame_done) fd_cnt++;
    if (zero_dim_err) begin
      zerr_cnt++;
      check("dim_valid_on_err", dim_valid, 0);
    end
    pend_lat = bx && byte_q[0][8];
    if (bx) void'(byte_q.pop_front());
    hold       = s_valid && !s_ready;
    prev_stall = m_valid && !m_ready;
    prev_pixel = m_pixel;
    cyc++;
  endtask

  task automatic run_idle(input string tag);
    int n = 0;
    while ((byte_q.size() != 0 || exp_q.size() != 0 || m_valid) && n < 5000) begin
      step();
      n++;
    end
    check({tag, "_bytes_left"}, byte_q.size(), 0);
    check({tag, "_pix_left"}, exp_q.size(), 0);
  endtask

  task automatic start_phase(input int rm, input int vp);
    ready_mode = rm;
    valid_pct  = vp;
    fd_cnt = 0; exp_fd = 0; zerr_cnt = 0; exp_zerr = 0;
  endtask

  task automatic end_phase(input string tag);
    run_idle(tag);
    repeat (2) step();
    check({tag, "_frame_done_cnt"}, fd_cnt, exp_fd);
    check({tag, "_zero_err_cnt"}, zerr_cnt, exp_zerr);
    check({tag, "_height"}, height, last_h);
    check({tag, "_width"}, width, last_w);
    check({tag, "_dim_valid_idle"}, dim_valid, 0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    s_valid = 1'b0; m_ready = 1'b0; b_s_valid = 1'b0; b_m_ready = 1'b0;
    hold = 0; prev_stall = 0; pend_lat = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_dim_valid", dim_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_zero_err", zero_dim_err, 0);
    check("rst_m_pixel", m_pixel, 0);
    check("rst_height", height, 0);
    check("rst_width", width, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_b_m_valid", b_m_valid, 0);
    reset = 1'b0;
  endtask

  task automatic run_b();
    logic [7:0]  bq[$];
    logic [32:0] bexp[$];
    logic [31:0] px;
    int n = 0;
    bq = {8'h01, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02};
    bexp.push_back({1'b1, 32'hDEADBEEF});
    for (int p = 0; p < 2; p++) begin
      px = $urandom;
      for (int k = 3; k >= 0; k--) bq.push_back(px[8*k +: 8]);
      bexp.push_back({(p == 1), px});
    end
    while ((bq.size() != 0 || bexp.size() != 0) && n < 300) begin
      @(negedge clk);
      b_s_valid = (bq.size() != 0);
      b_s_data  = (bq.size() != 0) ? bq[0] : 8'h00;
      b_m_ready = 1'($urandom_range(0, 1));
      #1;
      if (b_m_valid && b_m_ready) begin
        if (bexp.size() == 0) check("b_pix_extra", b_m_valid, 0);
        else check("b_pixel", {b_frame_done, b_m_pixel}, bexp.pop_front());
      end
      if (b_s_valid && b_s_ready) void'(bq.pop_front());
      n++;
    end
    check("b_pix_left", bexp.size(), 0);
    check("b_height", b_height, 1);
    check("b_width", b_width, 2);
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    b_s_valid = 1'b0; b_s_data = '0; b_m_ready = 1'b0;
    cyc = 0; last_h = 0; last_w = 0;
    reset_dut();

    start_phase(0, 100);
    push_frame(2, 2, 8'h01, 8'h01, 0);
    end_phase("basic");

    start_phase(1, 100);
    push_frame(2, 2, 8'h01, 8'h01, 0);
    end_phase("stall");

    start_phase(2, 80);
    push_frame(0, 5, 8'h00, 8'h00, 0);
    push_frame(1, 1, 8'hAA, 8'h11, 0);
    end_phase("zero_dim");

    start_phase(0, 100);
    push_frame(1, 1, 8'h10, 8'h01, 0);
    push_frame(1, 2, 8'h20, 8'h01, 0);
    end_phase("b2b");

    start_phase(2, 100);
    byte_q = {9'h000, 9'h001, 9'h000, 9'h002, 9'h011, 9'h022};
    run_idle("partial");
    check("pre_rst_dim_valid", dim_valid, 1);
    reset_dut();
    push_frame(1, 2, 8'h30, 8'h01, 1);
    end_phase("post_reset");

    start_phase(2, 70);
    for (int f = 0; f < 20; f++)
      push_frame(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3),
                 ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3), 8'h00, 8'h00, 1);
    push_frame(2, 3, 8'h00, 8'h00, 1);
    end_phase("random");

    run_b();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
